// File: rtl/el2_ifu_fetch_buf.sv
// el2_ifu_fetch_buf: circular fetch buffer between the I$ fetch stage and the aligner.
// Optional feature: define RV_IFU_FB_BYPASS_EN to forward a write straight to the head
// outputs in the same cycle when the buffer is empty.
module el2_ifu_fetch_buf #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     exu_flush_final,
  input  logic                     ic_hit_f,
  input  logic [1:0]               ic_fetch_val_f,
  input  logic [31:0]              ic_data_f,
  input  logic [1:0]               ic_access_fault_f,
  input  logic [1:0]               ic_access_fault_type_f,
  input  logic [30:0]              ifc_fetch_addr_f,
  input  logic                     aln_pop,
  output logic                     fb_ready,
  output logic                     fb_valid,
  output logic [31:0]              fb_data,
  output logic [1:0]               fb_val,
  output logic [1:0]               fb_fault,
  output logic [1:0]               fb_fault_type,
  output logic [30:0]              fb_pc,
  output logic [$clog2(DEPTH):0]   fb_count,
  output logic                     fb_overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  val;
    logic [1:0]  fault;
    logic [1:0]  fault_type;
    logic [30:0] pc;
  } fb_entry_t;

  fb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] entry_vld;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             overflow_err;

  fb_entry_t        wr_entry;
  fb_entry_t        head;
  logic             head_vld;
  logic             wr_req;
  logic             pop;
  logic             full;
  logic             bypass_consume;
  logic             store;
  logic             pop_stored;

  assign wr_entry = '{data: ic_data_f, val: ic_fetch_val_f, fault: ic_access_fault_f,
                      fault_type: ic_access_fault_type_f, pc: ifc_fetch_addr_f};
  assign head_vld = entry_vld[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign wr_req   = (ic_hit_f | (|ic_access_fault_f)) & (|ic_fetch_val_f) & ~exu_flush_final;

  // Head selection: stored entry first, then (optionally) the same-cycle write, else zeros.
  always_comb begin
    head     = '0;
    fb_valid = head_vld;
    if (head_vld) begin
      head = mem[rd_ptr];
    end
`ifdef RV_IFU_FB_BYPASS_EN
    else if (wr_req) begin
      head     = wr_entry;
      fb_valid = 1'b1;
    end
`endif
  end

  assign pop = aln_pop & fb_valid & ~exu_flush_final;

  // A bypassed write that is popped in the same cycle never touches storage.
`ifdef RV_IFU_FB_BYPASS_EN
  assign bypass_consume = ~head_vld & wr_req & pop;
`else
  assign bypass_consume = 1'b0;
`endif

  assign store      = wr_req & (~full | pop) & ~bypass_consume;
  assign pop_stored = pop & ~bypass_consume;

  // Pointer, occupancy, entry-valid and sticky overflow tracking.
  // NOTE: non-blocking assignments everywhere here so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      entry_vld    <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (exu_flush_final) begin
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        count     <= '0;
        entry_vld <= '0;
      end else begin
        // Clear before set: when full, a pop and a store hit the same slot and it must stay valid.
        if (pop_stored) begin
          entry_vld[rd_ptr] <= 1'b0;
          rd_ptr            <= rd_ptr + AW'(1);
        end
        if (store) begin
          entry_vld[wr_ptr] <= 1'b1;
          wr_ptr            <= wr_ptr + AW'(1);
        end
        case ({store, pop_stored})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
      if (wr_req & full & ~pop) begin
        overflow_err <= 1'b1;
      end
    end
  end

  // Entry payload storage.
  // NOTE: payload has no reset; entry_vld gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  assign fb_data         = head.data;
  assign fb_val          = head.val;
  assign fb_fault        = head.fault;
  assign fb_fault_type   = head.fault_type;
  assign fb_pc           = head.pc;
  assign fb_count        = count;
  assign fb_ready        = (count < CW'(DEPTH - 1));
  assign fb_overflow_err = overflow_err;

endmodule

// File: doc/el2_ifu_fetch_buf.md
EL2_IFU_FETCH_BUF -- requirements
Module: el2_ifu_fetch_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the number of fetch-buffer entries; legal values are powers of two, at least 2.
REQ-002 SHALL have ports (name, direction, width, meaning), as listed in REQ-003 to REQ-019.
REQ-003 clk  in  1  core clock; the block's only clock.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 exu_flush_final  in  1  pipeline flush; empties the buffer.
REQ-006 ic_hit_f  in  1  I$/ICCM hit from the memory controller.
REQ-007 ic_fetch_val_f  in  2  valid halfwords of the fetch.
REQ-008 ic_data_f  in  32  fetch data.
REQ-009 ic_access_fault_f  in  2  per-halfword access fault.
REQ-010 ic_access_fault_type_f  in  2  fault type.
REQ-011 ifc_fetch_addr_f  in  31  fetch PC [31:1].
REQ-012 aln_pop  in  1  the aligner consumes the head entry.
REQ-013 fb_ready  out  1  fetch control may issue a new request.
REQ-014 fb_valid  out  1  the head entry is valid.
REQ-015 fb_data, fb_val, fb_fault, fb_fault_type  out  32/2/2/2  head entry fields.
REQ-016 fb_pc  out  31  head entry PC.
REQ-017 fb_count  out  $clog2(DEPTH)+1  occupancy.
REQ-018 fb_overflow_err  out  1  sticky flag: a write was dropped because the buffer was full.
REQ-019 The block SHALL use one clock; reset SHALL be asynchronous and active-high, on ports clk and rst.

Function
REQ-020 A write SHALL occur when all of the following hold: (ic_hit_f | |ic_access_fault_f), |ic_fetch_val_f, and ~exu_flush_final.
REQ-021 A write SHALL store {data, val, fault, fault_type, pc} at the write pointer.
REQ-022 A pop SHALL occur when aln_pop & fb_valid & ~exu_flush_final; aln_pop while empty SHALL be ignored.
REQ-023 Storage SHALL be a circular FIFO; the read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-024 fb_count SHALL update next cycle: +1 on write only, -1 on pop only, unchanged on simultaneous write and pop.
REQ-025 Simultaneous write and pop when full SHALL be accepted, with no overflow.
REQ-026 A write when full without a pop SHALL be dropped, and fb_overflow_err SHALL set and hold until reset.
REQ-027 fb_ready SHALL equal (fb_count < DEPTH-1), registered-count based, reserving one slot for the in-flight fetch.
REQ-028 On exu_flush_final, pointers and count SHALL be 0 next cycle, and that cycle's write and pop SHALL be discarded.
REQ-029 fb_overflow_err SHALL be unaffected by flush.
REQ-030 The head fields SHALL be driven from the entry at the read pointer.
REQ-031 Fields SHALL be zero when the buffer is empty, unless bypass applies (REQ-036).
REQ-032 Write-to-fb_valid latency SHALL be 1 cycle when bypass is disabled.

Reset
REQ-033 On reset assertion, without waiting for a clock edge: fb_count=0, pointers=0, fb_valid=0, fb_ready=1, fb_overflow_err=0, and all head fields=0.
REQ-034 Reset SHALL clear the valid tracking of the entry storage; data contents may stay undefined.
REQ-035 Reset asserted mid-operation SHALL discard all entries, and the first write after release SHALL go to entry 0.

Configuration
REQ-036 With macro RV_IFU_FB_BYPASS_EN defined: when the buffer is empty and a write occurs, fb_valid and the head fields SHALL reflect the write inputs combinationally in the same cycle.
REQ-037 With RV_IFU_FB_BYPASS_EN defined: if aln_pop is also asserted in that cycle, the entry SHALL NOT be stored and the count SHALL stay 0.
REQ-038 Without RV_IFU_FB_BYPASS_EN: there SHALL be no bypass; outputs SHALL come only from registered entries, with 1-cycle latency.

Verification
REQ-039 Scenario, fill and drain: DEPTH=4, write PCs 0x100, 0x102, 0x104 with no pops -> fb_count=3, fb_ready=0; then pop three times -> fb_pc sequence 0x100, 0x102, 0x104, then fb_valid=0.
REQ-040 Scenario, overflow: fill to 4, then one more write with aln_pop=0 -> fb_count stays 4 and fb_overflow_err=1 through a following flush.
REQ-041 Scenario, full with simultaneous write and pop: count=4, write 0x200 with pop -> count=4, the next head is the old second entry, and no error.
REQ-042 Scenario, flush: count=3, with exu_flush_final=1 together with a write and a pop -> next cycle count=0, fb_valid=0, fb_ready=1.
REQ-043 Scenario, wrap and reset: 6 write/pop pairs produce correct PCs across pointer wrap; assert rst mid-stream -> outputs are zero immediately, and after release the first write appears with fb_pc equal to the written PC.
REQ-044 Scenario, bypass: with RV_IFU_FB_BYPASS_EN, empty buffer, write data 0xDEADBEEF with aln_pop=1 -> fb_data=0xDEADBEEF in the same cycle and count stays 0; without the macro, fb_valid=0 in that cycle and 1 in the next.
